// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and helpers for the IF/DM memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  // Arbiter FSM state encodings
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Read owner encodings
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Bits needed to hold the values 0..max_val inclusive
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive IF arbitration losses; at_max forces an IF win.
// Latency: registered count, at_max reflects the previous cycles' history.
// Backpressure: none; clear has priority over increment.
module mem_arb_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);
  import mem_port_arbiter_pkg::*;

  localparam int W = cnt_width(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment until saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between IF fetch and DM load/store; optional MEM_ARB_PERF_EN adds stall counters.
// Latency: grant is combinational in the issue cycle; read data returns MEM_LAT cycles later; writes complete in the issue cycle.
// Backpressure: one access in flight; requesters hold req until gnt, DM wins unless IF has lost STARVE_MAX times in a row.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]         perf_if_stall,
  output logic [31:0]         perf_dm_stall,
`endif
  output logic                busy
);
  import mem_port_arbiter_pkg::*;

  localparam int LAT_W = cnt_width(MEM_LAT - 1);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;

  logic starve_at_max;
  logic if_win;
  logic dm_win;
  logic issue_rd;

  // Arbitration: only in IDLE and never during reset; DM wins unless IF is starved
  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if ((state_q == ARB_IDLE) && !rst) begin
      if (dm_req && !(starve_at_max && if_req)) begin
        dm_win = 1'b1;
      end else if (if_req) begin
        if_win = 1'b1;
      end
    end
  end

  assign issue_rd = if_win | (dm_win & ~dm_we);

  // Starvation tracking: IF losses to DM count up, an IF grant or idle IF clears
  mem_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .clr    (~if_req | if_win),
    .inc    (dm_win & if_req),
    .at_max (starve_at_max)
  );

  // State register: owner and latency counter travel with the FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_IF;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // Next state: reads wait out the memory latency, writes never leave IDLE
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (issue_rd) begin
          owner_d = dm_win ? OWN_DM : OWN_IF;
          if (MEM_LAT == 1) begin
            state_d = ARB_RESP;
          end else begin
            state_d   = ARB_WAIT;
            lat_cnt_d = LAT_W'(1);
          end
        end
      end
      ARB_WAIT: begin
        if (lat_cnt_q == LAT_W'(MEM_LAT - 1)) begin
          state_d   = ARB_RESP;
          lat_cnt_d = '0;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d   = ARB_IDLE;
        lat_cnt_d = '0;
      end
    endcase
  end

  // Outputs: memory port mirrors the winner; read data is routed to the registered owner
  always_comb begin
    if_gnt    = if_win;
    dm_gnt    = dm_win;
    mem_en    = if_win | dm_win;
    mem_we    = dm_win & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (dm_win) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_be    = dm_be;
    end else if (if_win) begin
      mem_addr = if_addr;
      mem_be   = '1;
    end
    if_rvalid = (state_q == ARB_RESP) && !rst && (owner_q == OWN_IF);
    dm_rvalid = (state_q == ARB_RESP) && !rst && (owner_q == OWN_DM);
    if_rdata  = mem_rdata;
    dm_rdata  = mem_rdata;
    busy      = (state_q != ARB_IDLE) && !rst;
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_stall_q, perf_if_stall_d;
  logic [31:0] perf_dm_stall_q, perf_dm_stall_d;

  // Stall counters: one per requester, counting cycles of request without grant
  always_comb begin
    perf_if_stall_d = perf_if_stall_q + ((if_req && !if_gnt) ? 32'd1 : 32'd0);
    perf_dm_stall_d = perf_dm_stall_q + ((dm_req && !dm_gnt) ? 32'd1 : 32'd0);
  end

  // Stall counter registers, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_stall_q <= '0;
      perf_dm_stall_q <= '0;
    end else begin
      perf_if_stall_q <= perf_if_stall_d;
      perf_dm_stall_q <= perf_dm_stall_d;
    end
  end

  assign perf_if_stall = perf_if_stall_q;
  assign perf_dm_stall = perf_dm_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a transaction-level reference model.
// Latency: expects read data MEM_LAT cycles after the grant.
// Backpressure: drivers hold each request until its grant (optionally dropping it early).
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [BW-1:0] dm_be;
  logic          dm_gnt, dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata;
  logic          busy;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   perf_if_stall, perf_dm_stall;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata),
`ifdef MEM_ARB_PERF_EN
    .perf_if_stall(perf_if_stall), .perf_dm_stall(perf_dm_stall),
`endif
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- memory environment (driven by the DUT's mem_* port) ----------------
  logic [31:0] env_mem [int];
  logic [31:0] rd_pipe [LAT];
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    int idx;
    logic [31:0] w;
    idx = int'(mem_addr[9:2]);
    w = env_mem.exists(idx) ? env_mem[idx] : 32'h0;
    if (mem_en && mem_we) env_mem[idx] = merge(w, mem_wdata, mem_be);
    // slots with no read carry junk so misrouted or mistimed data is visible
    rd_pipe[0] <= (mem_en && !mem_we) ? w : $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // ---------------- reference model + scoreboard monitor ----------------
  typedef struct { int due; logic [31:0] data; } exp_t;
  exp_t        if_q[$];
  exp_t        dm_q[$];
  logic [31:0] ref_mem [int];
  int          free_at  = 0;
  int          starve   = 0;
  int          rd_issue = -100;
  logic [31:0] exp_pif  = 0;
  logic [31:0] exp_pdm  = 0;
  bit          if_gnt_seen = 0;
  bit          dm_gnt_seen = 0;

  always @(negedge clk) begin
    bit          w_if, w_dm, e_busy, e_ifrv, e_dmrv;
    int          idx;
    logic [31:0] cur;
`ifdef MEM_ARB_PERF_EN
    check("perf_if_stall", perf_if_stall, exp_pif);
    check("perf_dm_stall", perf_dm_stall, exp_pdm);
`endif
    w_if = 0; w_dm = 0; e_busy = 0;
    if (rst) begin
      if_q.delete(); dm_q.delete();
      free_at = cyc + 1; starve = 0; rd_issue = -100;
    end else begin
      e_busy = (cyc > rd_issue) && (cyc <= rd_issue + LAT);
      if (cyc >= free_at) begin
        if (dm_req && !(starve == SMAX && if_req)) w_dm = 1;
        else if (if_req) w_if = 1;
      end
    end
    e_ifrv = (if_q.size() > 0) && (if_q[0].due == cyc);
    e_dmrv = (dm_q.size() > 0) && (dm_q[0].due == cyc);

    check("if_gnt", if_gnt, w_if);
    check("dm_gnt", dm_gnt, w_dm);
    check("mem_en", mem_en, w_if | w_dm);
    check("busy", busy, e_busy);
    check("if_rvalid", if_rvalid, e_ifrv);
    check("dm_rvalid", dm_rvalid, e_dmrv);
    if (e_ifrv) begin
      if (if_rvalid) check("if_rdata", if_rdata, if_q[0].data);
      void'(if_q.pop_front());
    end
    if (e_dmrv) begin
      if (dm_rvalid) check("dm_rdata", dm_rdata, dm_q[0].data);
      void'(dm_q.pop_front());
    end

    if (!rst) begin
      if (!if_req || w_if) starve = 0;
      else if (w_dm) starve = (starve + 1 > SMAX) ? SMAX : starve + 1;
      if (w_if) begin
        idx = int'(if_addr[9:2]);
        cur = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
        check("mem_we_if", mem_we, 0);
        check("mem_addr_if", mem_addr, if_addr);
        check("mem_be_if", 32'(mem_be), 32'hF);
        if_q.push_back('{cyc + LAT, cur});
        free_at = cyc + LAT + 1; rd_issue = cyc;
      end else if (w_dm) begin
        idx = int'(dm_addr[9:2]);
        cur = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
        check("mem_we_dm", mem_we, dm_we);
        check("mem_addr_dm", mem_addr, dm_addr);
        if (dm_we) begin
          check("mem_be_dm", 32'(mem_be), 32'(dm_be));
          check("mem_wdata_dm", mem_wdata, dm_wdata);
          ref_mem[idx] = merge(cur, dm_wdata, dm_be);
          free_at = cyc + 1;
        end else begin
          dm_q.push_back('{cyc + LAT, cur});
          free_at = cyc + LAT + 1; rd_issue = cyc;
        end
      end
      if (if_req && !w_if) exp_pif = exp_pif + 1;
      if (dm_req && !w_dm) exp_pdm = exp_pdm + 1;
    end else begin
      exp_pif = 0; exp_pdm = 0;
    end
    if_gnt_seen = (if_gnt === 1'b1);
    dm_gnt_seen = (dm_gnt === 1'b1);
  end

  // ---------------- requester drivers ----------------
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } txn_t;
  txn_t        dm_txq[$];
  logic [31:0] if_txq[$];
  bit          drop_en = 0;

  initial begin : dm_drv
    txn_t t;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
    forever begin
      @(posedge clk); #1;
      if (dm_req && dm_gnt_seen) dm_req = 0;
      if (!dm_req) begin
        if (dm_txq.size() > 0) begin
          t = dm_txq.pop_front();
          dm_req = 1; dm_we = t.we; dm_addr = t.addr; dm_wdata = t.wdata; dm_be = t.be;
        end else begin
          dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom);
        end
      end else if (drop_en && $urandom_range(0, 19) == 0) begin
        dm_req = 0;
      end
    end
  end

  initial begin : if_drv
    if_req = 0; if_addr = 0;
    forever begin
      @(posedge clk); #1;
      if (if_req && if_gnt_seen) if_req = 0;
      if (!if_req) begin
        if (if_txq.size() > 0) begin
          if_addr = if_txq.pop_front(); if_req = 1;
        end else begin
          if_addr = $urandom;
        end
      end else if (drop_en && $urandom_range(0, 19) == 0) begin
        if_req = 0;
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    return {22'b0, 8'($urandom), 2'b00};
  endfunction

  task automatic push_dm(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
    dm_txq.push_back('{we, a, d, be});
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk); #1;
      done = (dm_txq.size() == 0) && (if_txq.size() == 0) && !if_req && !dm_req &&
             (if_q.size() == 0) && (dm_q.size() == 0);
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout cyc=%0d got=pending expected=idle", cyc);
    end
  endtask

  initial begin : main
    bit seen;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // preload then IF read of 0x100
    push_dm(1, 32'h100, 32'h1234_5678, 4'hF);
    wait_drain();
    if_txq.push_back(32'h100);
    wait_drain();

    // simultaneous IF and DM read: DM first, IF after the read completes
    push_dm(1, 32'h200, 32'hCAFE_F00D, 4'hF);
    wait_drain();
    if_txq.push_back(32'h300);
    push_dm(0, 32'h200, 32'h0, 4'h0);
    wait_drain();

    // partial write then back-to-back read of 0x40
    push_dm(1, 32'h40, 32'hDEAD_BEEF, 4'b0011);
    push_dm(0, 32'h40, 32'h0, 4'h0);
    wait_drain();

    // starvation: continuous DM writes while IF waits
    for (int i = 0; i < 7; i++) push_dm(1, 32'h80 + 32'(4 * i), 32'(i + 1), 4'hF);
    if_txq.push_back(32'h100);
    wait_drain();

    // reset one cycle after a read grant
    if_txq.push_back(32'h100);
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk); #1;
      seen = if_gnt_seen;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL rst_grant_timeout cyc=%0d got=no_gnt expected=gnt", cyc);
    end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    wait_drain();
    if_txq.push_back(32'h40);
    wait_drain();

    // randomized traffic with early drops and occasional resets
    drop_en = 1;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #2;
      if (if_txq.size() < 2 && $urandom_range(0, 3) == 0) if_txq.push_back(rand_addr());
      if (dm_txq.size() < 2 && $urandom_range(0, 2) == 0)
        push_dm(1'($urandom), rand_addr(), $urandom, 4'($urandom));
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 0;
    drop_en = 0;
    wait_drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
